alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Upstream issue stage for the 8-bit combinational ALU (operands a/b, 3-bit opcode, 8-bit result plus carry). It accepts operand/opcode commands over a valid/ready handshake and buffers them in a small in-order FIFO. It presents the FIFO head to the ALU and registers the ALU result and carry into a single output slot with its own valid/ready handshake. It also counts completed operations for debug and performance monitoring.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  FIFO can accept; equals !full
cmd_a_i  in  8  operand a
cmd_b_i  in  8  operand b
cmd_op_i  in  3  ALU opcode (000 add, 001 sub, 010 shl, 011 shr, 100 and, 101 or, 110 xor, 111 eq)
alu_a_o  out  8  to ALU a input
alu_b_o  out  8  to ALU b input
alu_op_o  out  3  to ALU opcode input
alu_res_i  in  8  ALU result (combinational from alu_*_o)
alu_carry_i  in  1  ALU carry
res_valid_o  out  1  result slot holds valid data
res_ready_i  in  1  downstream accepts the result
res_data_o  out  8  registered result
res_carry_o  out  1  registered carry
res_op_o  out  3  opcode that produced res_data_o
level_o  out  $clog2(DEPTH)+1  FIFO occupancy
done_cnt_o  out  CNT_W  results consumed downstream

Behaviour:
- Reset is synchronous and active-high on clk. All of the following are zero after reset: FIFO pointers, level_o, res_valid_o, res_data_o, res_carry_o, res_op_o, done_cnt_o.
- Push: cmd_valid_i && cmd_ready_o at a rising edge writes {a,b,op} at the write pointer. The write pointer wraps from DEPTH-1 to 0.
- cmd_ready_o = (level_o != DEPTH). It is purely a function of registered level. A push is not accepted at full even if a pop happens in the same cycle; there is no bypass.
- ALU drive: when the FIFO is non-empty, alu_a_o, alu_b_o and alu_op_o equal the head entry, combinationally from the storage and read pointer. When the FIFO is empty, all three are 0.
- Pop/capture condition: capture = !empty && (!res_valid_o || res_ready_i). When capture is true at the edge:
  - res_data_o <= alu_res_i, res_carry_o <= alu_carry_i, res_op_o <= head op
  - res_valid_o <= 1
  - the read pointer advances and wraps.
- Drain: res_valid_o && res_ready_i && empty sets res_valid_o <= 0. The data registers hold their last value.
- Result stability: while res_valid_o && !res_ready_i, res_data_o, res_carry_o and res_op_o are held stable.
- Throughput and latency:
  - One result per cycle with res_ready_i held high.
  - A command accepted at edge N produces res_valid_o high after edge N+1, provided the FIFO was empty and the slot was free.
  - There is no bypass from cmd_* straight to the ALU.
- Level: level_o updates as +1 on push only, -1 on capture only, unchanged when push and capture happen together. Ordering is strictly FIFO.
- Counter: done_cnt_o increments on every res_valid_o && res_ready_i and wraps modulo 2^CNT_W.
- Reset mid-operation discards all queued commands and any pending result. No result is emitted after reset for commands accepted before it.
- No arithmetic is performed locally. The ALU result and carry are captured unmodified.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD..OP_EQ (3'b000..3'b111)
  - DATA_W = 8, OP_W = 3
  - a packed command struct/type {a, b, op} of width 19.
- One natural sub-module, alu_cmd_fifo:
  - parameterised DEPTH, width 19
  - push/pop, full/empty, level
  - the sequencer instantiates it plus the result register and counter.
- The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
1. Push {a=0x05,b=0x03,op=000} with res_ready_i=1 and the ALU attached. res_valid_o rises one edge after acceptance, with res_data_o=0x08, res_carry_o=0, res_op_o=000; done_cnt_o=1 after the handshake.
2. Push {0xFF,0x01,000}, then {0x05,0x03,001}, then {0x05,0x03,010} back-to-back with res_ready_i=1. Results appear on consecutive cycles, in order: 0x00/carry=1, then 0x02, then 0x28.
3. Hold res_ready_i=0 and offer 6 commands. The first is captured into the result slot and 4 fill the FIFO: level_o=4 and cmd_ready_o=0, and the 6th stalls. res_data_o is stable throughout. Release res_ready_i: results drain in order and the 6th is accepted when level drops to 3.
4. At full, assert res_ready_i and cmd_valid_i together. A pop occurs but no push that cycle (level 4→3). The push is accepted on the next cycle.
5. With 3 queued and res_valid_o=1, assert reset for one cycle. Afterwards level_o=0, res_valid_o=0, done_cnt_o=0 and alu_*_o=0, and no stale results appear within 10 idle cycles.
6. Wrap test with DEPTH=4: push and pop 9 commands of opcode 100 (AND) with a=0xF0 and b=0x3C..0x44. Results are {a&b} in order across the pointer wrap; done_cnt_o=9.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode encodings, widths and the
// packed command word carried through the command FIFO.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CMD_W  = 2 * DATA_W + OP_W;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_SHL = 3'b010;
  localparam logic [OP_W-1:0] OP_SHR = 3'b011;
  localparam logic [OP_W-1:0] OP_AND = 3'b100;
  localparam logic [OP_W-1:0] OP_OR  = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR = 3'b110;
  localparam logic [OP_W-1:0] OP_EQ  = 3'b111;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// In-order command FIFO with combinational head read and registered occupancy.
// Callers must not push when full or pop when empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = CMD_W,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so plain increment wraps the pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for an external combinational ALU: buffers commands, drives the
// FIFO head to the ALU, registers result/carry into a handshaked output slot.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [DATA_W-1:0]         cmd_a_i,
  input  logic [DATA_W-1:0]         cmd_b_i,
  input  logic [OP_W-1:0]           cmd_op_i,
  output logic [DATA_W-1:0]         alu_a_o,
  output logic [DATA_W-1:0]         alu_b_o,
  output logic [OP_W-1:0]           alu_op_o,
  input  logic [DATA_W-1:0]         alu_res_i,
  input  logic                      alu_carry_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [DATA_W-1:0]         res_data_o,
  output logic                      res_carry_o,
  output logic [OP_W-1:0]           res_op_o,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic [CNT_W-1:0]          done_cnt_o
);

  alu_cmd_t         wr_cmd;
  alu_cmd_t         head;
  logic [CMD_W-1:0] rdata;
  logic             full;
  logic             empty;
  logic             push;
  logic             capture;
  logic             consume;

  assign wr_cmd      = '{a: cmd_a_i, b: cmd_b_i, op: cmd_op_i};
  assign head        = alu_cmd_t'(rdata);
  assign cmd_ready_o = !full;
  assign push        = cmd_valid_i && !full;
  assign capture     = !empty && (!res_valid_o || res_ready_i);
  assign consume     = res_valid_o && res_ready_i;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wr_cmd),
    .pop   (capture),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level_o)
  );

  // Storage is not reset, so gate the head to zero while the FIFO is empty.
  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = '0;
    if (!empty) begin
      alu_a_o  = head.a;
      alu_b_o  = head.b;
      alu_op_o = head.op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_carry_o <= 1'b0;
      res_op_o    <= '0;
      done_cnt_o  <= '0;
    end else begin
      if (capture) begin
        res_valid_o <= 1'b1;
        res_data_o  <= alu_res_i;
        res_carry_o <= alu_carry_i;
        res_op_o    <= head.op;
      end else if (consume) begin
        res_valid_o <= 1'b0;
      end
      if (consume) done_cnt_o <= done_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: attached behavioural ALU, table of directed
// vectors, hand-written corner sequences and a queue-based random reference.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, cmd_valid, cmd_ready, res_valid, res_ready, res_carry, alu_carry;
  logic [7:0]        cmd_a, cmd_b, alu_a, alu_b, alu_res, res_data;
  logic [2:0]        cmd_op, alu_op, res_op;
  logic [2:0]        level;
  logic [CNT_W-1:0]  done_cnt;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_op_i(cmd_op),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_res_i(alu_res), .alu_carry_i(alu_carry),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_carry_o(res_carry), .res_op_o(res_op),
    .level_o(level), .done_cnt_o(done_cnt)
  );

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_SHL:  return {1'b0, 8'(a << b[2:0])};
      OP_SHR:  return {1'b0, 8'(a >> b[2:0])};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      default: return {8'd0, (a == b)};
    endcase
  endfunction

  always_comb {alu_carry, alu_res} = alu_f(alu_a, alu_b, alu_op);

  // Reference: queue of accepted commands plus one result slot.
  alu_cmd_t         mq[$];
  logic             m_rv;
  logic [7:0]       m_rd;
  logic             m_rc;
  logic [2:0]       m_rop;
  logic [CNT_W-1:0] m_cnt;
  logic [7:0]       seen[$];
  int               n_vec = 0;
  int               n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic rdy);
    bit push, cap, hs;
    alu_cmd_t h;
    logic [8:0] r;
    reset = rst; cmd_valid = v; cmd_a = a; cmd_b = b; cmd_op = op; res_ready = rdy;
    if (rst) begin
      mq.delete(); m_rv = 0; m_rd = '0; m_rc = 0; m_rop = '0; m_cnt = '0;
    end else begin
      if (res_valid && rdy) seen.push_back(res_data);
      push = v && (mq.size() < DEPTH);
      cap  = (mq.size() > 0) && (!m_rv || rdy);
      hs   = m_rv && rdy;
      if (hs) m_cnt++;
      if (cap) begin
        h = mq.pop_front();
        r = alu_f(h.a, h.b, h.op);
        {m_rc, m_rd} = r;
        m_rop = h.op;
        m_rv = 1;
      end else if (hs) m_rv = 0;
      if (push) mq.push_back('{a: a, b: b, op: op});
    end
    @(posedge clk);
    #1;
    check("cmd_ready", cmd_ready, mq.size() < DEPTH);
    check("level", level, mq.size());
    check("alu_a", alu_a, mq.size() > 0 ? mq[0].a : 8'h00);
    check("alu_b", alu_b, mq.size() > 0 ? mq[0].b : 8'h00);
    check("alu_op", alu_op, mq.size() > 0 ? mq[0].op : 3'h0);
    check("res_valid", res_valid, m_rv);
    check("res_data", res_data, m_rd);
    check("res_carry", res_carry, m_rc);
    check("res_op", res_op, m_rop);
    check("done_cnt", done_cnt, m_cnt);
  endtask

  typedef struct {
    logic v; logic [7:0] a; logic [7:0] b; logic [2:0] op; logic rdy;
    logic ev; logic [7:0] ed; logic ec; logic [2:0] eop; logic [15:0] ecnt;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{1, 8'h05, 8'h03, OP_ADD, 1,  0, 8'h00, 0, 3'h0, 16'd0};
    tbl[1] = '{1, 8'hFF, 8'h01, OP_ADD, 1,  1, 8'h08, 0, OP_ADD, 16'd0};
    tbl[2] = '{1, 8'h05, 8'h03, OP_SUB, 1,  1, 8'h00, 1, OP_ADD, 16'd1};
    tbl[3] = '{1, 8'h05, 8'h03, OP_SHL, 1,  1, 8'h02, 0, OP_SUB, 16'd2};
    tbl[4] = '{0, 8'h00, 8'h00, OP_ADD, 1,  1, 8'h28, 0, OP_SHL, 16'd3};
    tbl[5] = '{0, 8'h00, 8'h00, OP_ADD, 1,  0, 8'h28, 0, OP_SHL, 16'd4};

    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("rst_level", level, 0);
    check("rst_valid", res_valid, 0);
    check("rst_cnt", done_cnt, 0);

    // Single op latency and back-to-back ordering
    for (int i = 0; i < 6; i++) begin
      cycle(0, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), res_valid, tbl[i].ev);
      check($sformatf("tbl%0d_data", i), res_data, tbl[i].ed);
      check($sformatf("tbl%0d_carry", i), res_carry, tbl[i].ec);
      check($sformatf("tbl%0d_op", i), res_op, tbl[i].eop);
      check($sformatf("tbl%0d_cnt", i), done_cnt, tbl[i].ecnt);
    end

    // Stall with res_ready low: slot + full FIFO, sixth command blocked
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'h10 + 8'(i), 8'h01, OP_ADD, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 8'h15, 8'h01, OP_ADD, 0);
      check("stall_level", level, 4);
      check("stall_ready", cmd_ready, 0);
      check("stall_data", res_data, 8'h11);
    end
    seen.delete();
    cycle(0, 1, 8'h15, 8'h01, OP_ADD, 1);
    check("full_pop_level", level, 3);
    cycle(0, 1, 8'h15, 8'h01, OP_ADD, 1);
    check("late_push_level", level, 3);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 1);
    check("drain_count", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++)
      check($sformatf("drain%0d", i), seen[i], 8'h11 + 8'(i));

    // Reset with work pending
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'h20 + 8'(i), 8'h02, OP_XOR, 0);
    check("pre_rst_level", level, 3);
    check("pre_rst_valid", res_valid, 1);
    cycle(1, 0, 0, 0, 0, 0);
    check("post_rst_level", level, 0);
    check("post_rst_valid", res_valid, 0);
    check("post_rst_cnt", done_cnt, 0);
    check("post_rst_alu_a", alu_a, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      check("post_rst_idle", res_valid, 0);
    end

    // Pointer wrap with AND stream
    cycle(1, 0, 0, 0, 0, 0);
    seen.delete();
    for (int i = 0; i < 9; i++) cycle(0, 1, 8'hF0, 8'h3C + 8'(i), OP_AND, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);
    check("wrap_count", seen.size(), 9);
    for (int i = 0; i < 9 && i < seen.size(); i++)
      check($sformatf("wrap%0d", i), seen[i], 8'hF0 & (8'h3C + 8'(i)));
    check("wrap_cnt", done_cnt, 9);

    // Randomised traffic with phases of light and heavy back-pressure
    for (int i = 0; i < 3000; i++) begin
      int unsigned rdy_pct;
      rdy_pct = ((i / 200) % 2 == 0) ? 30 : 85;
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
            8'($urandom), 8'($urandom), 3'($urandom),
            ($urandom_range(0, 99) < rdy_pct));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
